// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one memory port between the pipeline MEM stage (P)
// and a debug/DMA master (D), inserting access latency and stalling P until done.
module dmem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          p_req_i,
   input  logic          p_we_i,
   input  logic [AW-1:0] p_addr_i,
   input  logic [DW-1:0] p_wdata_i,
   output logic [DW-1:0] p_rdata_o,
   output logic          p_stall_o,
   input  logic          d_valid_i,
   input  logic          d_we_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic [DW-1:0] d_wdata_i,
   output logic          d_ready_o,
   output logic          d_rvalid_o,
   output logic [DW-1:0] d_rdata_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   output logic          mem_read_o,
   output logic          mem_write_o,
   input  logic [DW-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t        state, state_nxt;
   logic          owner_d;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic [3:0]    cnt_q;
   logic [3:0]    starve_q;
   logic          starved, grant_p, grant_d, sample;

   // D is forced through only when it has watched STARVE_MAX P grants go by.
   assign starved = d_valid_i && (starve_q == STARVE_LIM);
   assign grant_p = (state == IDLE) && p_req_i && !starved;
   assign grant_d = (state == IDLE) && !grant_p && d_valid_i;

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign p_rdata_o   = rdata_q;
   assign d_rdata_o   = (state == RESP && owner_d) ? rdata_q : '0;

   always_comb begin
      state_nxt   = state;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      d_ready_o   = 1'b0;
      d_rvalid_o  = 1'b0;
      p_stall_o   = p_req_i;
      sample      = 1'b0;
      case (state)
         IDLE: begin
            d_ready_o = grant_d;
            if (grant_p || grant_d) state_nxt = ACCESS;
         end
         ACCESS: begin
            if (we_q) begin
               mem_write_o = 1'b1;
               state_nxt   = RESP;
            end else begin
               mem_read_o = 1'b1;
               if (cnt_q == 4'd0) begin
                  sample    = 1'b1;
                  state_nxt = RESP;
               end
            end
         end
         RESP: begin
            state_nxt = IDLE;
            if (owner_d) d_rvalid_o = 1'b1;
            else         p_stall_o  = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         owner_d  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
      end else begin
         state <= state_nxt;
         if (grant_p || grant_d) begin
            owner_d <= grant_d;
            we_q    <= grant_d ? d_we_i    : p_we_i;
            addr_q  <= grant_d ? d_addr_i  : p_addr_i;
            wdata_q <= grant_d ? d_wdata_i : p_wdata_i;
            cnt_q   <= LAT_M1;
         end
         if (state == ACCESS && !we_q && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
         if (sample) rdata_q <= mem_rdata_i;
         // Writes return zero so the response bus never shows stale read data.
         if (state == ACCESS && we_q) rdata_q <= '0;
         if (grant_d)
            starve_q <= '0;
         else if (grant_p && d_valid_i && starve_q != STARVE_LIM)
            starve_q <= starve_q + 4'd1;
      end
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data memory between two requesters: the pipeline MEM stage (port P) and a debug/DMA master (port D).
- Adds a configurable memory access latency and stalls the pipeline until its access completes.
- Anti-starvation counter guarantees D forward progress while P has default priority.
- Sits between the MEM stage control signals (memread/memwrite, ALU-result address, register-file store data) and the Data_Memory instance.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 2, cycles mem_read_o is held before read data is sampled; legal range 1..8.
- STARVE_MAX, 4, consecutive P grants with D pending before D is forced through; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- p_req_i  in  1  pipeline access request (memread | memwrite); held stable while p_stall_o=1.
- p_we_i  in  1  1=store, 0=load.
- p_addr_i  in  AW  pipeline address.
- p_wdata_i  in  DW  store data.
- p_rdata_o  out  DW  load data, valid in the cycle p_stall_o falls.
- p_stall_o  out  1  freeze the pipeline.
- d_valid_i  in  1  D request valid.
- d_we_i  in  1  D write.
- d_addr_i  in  AW  D address.
- d_wdata_i  in  DW  D write data.
- d_ready_o  out  1  D request accepted this cycle.
- d_rvalid_o  out  1  D completion pulse.
- d_rdata_o  out  DW  D read data (0 for writes).
- mem_addr_o  out  AW  to memory.
- mem_wdata_o  out  DW  to memory.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_rdata_i  in  DW  memory read data.

Behaviour:
- Reset (rst_i=0, async):
  - State returns to IDLE; owner, latched request, latency counter and starve counter are cleared.
  - mem_read_o, mem_write_o, d_ready_o and d_rvalid_o are 0.
  - All data/address outputs are 0.
  - p_stall_o = p_req_i, since it is combinational.
  - Any in-flight access is dropped without rollback.
- FSM states: IDLE, ACCESS, RESP.
- IDLE arbitration:
  - P wins if p_req_i && !(d_valid_i && starve==STARVE_MAX).
  - Otherwise D wins if d_valid_i.
  - Otherwise stay in IDLE.
  - On grant: latch we/addr/wdata, set the owner, load the latency counter to MEM_LAT-1, go to ACCESS.
  - d_ready_o=1 combinationally in the IDLE cycle that grants D; D fields are captured at that edge.
- ACCESS:
  - mem_addr_o and mem_wdata_o are driven from the latched registers.
  - Write: mem_write_o=1 for exactly one cycle, then go to RESP.
  - Read: mem_read_o=1 for MEM_LAT cycles. mem_rdata_i is sampled on the last cycle (counter==0), then go to RESP.
  - mem_read_o and mem_write_o are never both 1.
  - Outside ACCESS, both strobes are 0 and mem_addr_o/mem_wdata_o hold their last values.
- RESP (one cycle):
  - Owner P: p_stall_o=0 and p_rdata_o = sampled data. The pipeline advances at this edge.
  - Owner D: d_rvalid_o=1 and d_rdata_o = sampled data (0 if write).
  - Next state is IDLE.
- p_stall_o = p_req_i && !(state==RESP && owner==P).
- Pipeline load latency: with MEM_LAT=L, stall lasts L+1 cycles and the pipeline proceeds on cycle L+2. Store latency: stall lasts 2 cycles.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each P grant made while d_valid_i=1.
  - Cleared on a D grant.
  - Unchanged on a P grant with d_valid_i=0.
- Request changes: d_valid_i dropping before d_ready_o is allowed (request withdrawn). p_req_i dropping mid-access is ignored; the access completes.
- Address and data pass through unmodified; alignment is the requester's responsibility.

Test Plan:
- MEM_LAT=2, P load addr 0x10, no D: p_stall_o=1 for 3 cycles; mem_read_o high for 2 cycles; on cycle 4 p_stall_o=0 and p_rdata_o = mem word at 0x10.
- P store addr 0x20, data 0xDEADBEEF: mem_write_o pulses one cycle with mem_addr_o=0x20 and mem_wdata_o=0xDEADBEEF; stall lasts 2 cycles.
- D read with P idle: d_ready_o=1 in the first cycle; d_rvalid_o pulses after MEM_LAT+1 cycles with the correct d_rdata_o; p_stall_o stays 0.
- STARVE_MAX=2, P requesting back-to-back and D held valid: grant order is P, P, D, P; d_ready_o asserts only on the third grant; starve counter clears to 0.
- Simultaneous P and D in IDLE with starve=0: P granted, d_ready_o=0, D accepted in the next IDLE cycle.
- rst_i asserted mid-ACCESS on a read: mem_read_o drops immediately, state is IDLE after release, and a new P request completes normally.
